// File: rtl/job_issuer_pkg.sv
// Shared definitions for the job issuer: default sizing and the control FSM encoding.
package job_issuer_pkg;

    localparam int W_DEF         = 16;
    localparam int DEPTH_DEF     = 4;
    localparam int START_CYC_DEF = 2;
    localparam int TIMEOUT_DEF   = 255;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        RESULT    = 2'd3
    } state_t;

endpackage

// File: rtl/job_fifo.sv
// Operand-pair FIFO: storage, wrap-around pointers and occupancy count.
// Callers qualify push_i with not_full_o and pop_i with a non-zero count.
module job_fifo
    import job_issuer_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               a_i,
    input  logic [W-1:0]               b_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_a_o,
    output logic [W-1:0]               head_b_o,
    output logic                       not_full_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [2*W-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    assign head_a_o   = mem[rd_ptr_q][2*W-1:W];
    assign head_b_o   = mem[rd_ptr_q][W-1:0];
    assign not_full_o = (count_q < CW'(DEPTH));
    assign count_o    = count_q;

    // Pointer advance with explicit wrap and occupancy update; push+pop leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i)
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        if (pop_i)
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers; reset empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_i)
            mem[wr_ptr_q] <= {a_i, b_i};
    end

endmodule

// File: rtl/job_issuer.sv
// Job issuer: queues operand pairs, issues one job at a time to a datapath
// controller, waits for done (with timeout) and holds the result until consumed.
module job_issuer
    import job_issuer_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int START_CYC = START_CYC_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_a,
    input  logic [W-1:0]           in_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [W-1:0]           res_data,
    output logic                   res_err,
    output logic                   dp_start,
    output logic [W-1:0]           dp_a,
    output logic [W-1:0]           dp_b,
    input  logic                   dp_done,
    input  logic [W-1:0]           dp_result,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(START_CYC + 1);

    state_t         state_q, state_d;
    logic [SW-1:0]  scnt_q, scnt_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [W-1:0]   dp_a_q, dp_a_d, dp_b_q, dp_b_d;
    logic [W-1:0]   res_data_q, res_data_d;
    logic           res_err_q, res_err_d;
    logic           res_valid_q, res_valid_d;

    logic           push, pop, not_full;
    logic [W-1:0]   head_a, head_b;
    logic [CW-1:0]  count;

    // in_ready is forced low during reset so nothing is accepted into a queue being cleared.
    assign in_ready   = not_full && !rst;
    assign push       = in_valid && in_ready;
    assign fifo_count = count;

    assign dp_start  = (state_q == START);
    assign busy      = (state_q != IDLE);
    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

    job_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .a_i        (in_a),
        .b_i        (in_b),
        .pop_i      (pop),
        .head_a_o   (head_a),
        .head_b_o   (head_b),
        .not_full_o (not_full),
        .count_o    (count)
    );

    // Next-state and datapath-register logic for the issue FSM.
    always_comb begin
        state_d     = state_q;
        scnt_d      = scnt_q;
        timer_d     = timer_q;
        dp_a_d      = dp_a_q;
        dp_b_d      = dp_b_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        res_valid_d = res_valid_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                // Operands are latched at pop and held until the next pop,
                // because the datapath loads them after dp_start falls.
                if (count != '0 && !res_valid_q) begin
                    pop     = 1'b1;
                    dp_a_d  = head_a;
                    dp_b_d  = head_b;
                    scnt_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (scnt_q == SW'(START_CYC - 1)) begin
                    scnt_d  = '0;
                    timer_d = TW'(1);
                    state_d = WAIT_DONE;
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            WAIT_DONE: begin
                // done beats the timeout when both land in the same cycle
                if (dp_done) begin
                    res_data_d  = dp_result;
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    timer_d     = '0;
                    state_d     = RESULT;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    res_data_d  = '0;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    timer_d     = '0;
                    state_d     = RESULT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, counters and output registers; reset abandons any in-flight job.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            scnt_q      <= '0;
            timer_q     <= '0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            timer_q     <= timer_d;
            dp_a_q      <= dp_a_d;
            dp_b_q      <= dp_b_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
        end
    end

endmodule

// File: tb/tb_job_issuer.sv
// Bench for job_issuer: datapath responder model, protocol monitor and
// an in-order result scoreboard built from the pushed operand pairs.
module tb_job_issuer;

    localparam int W = 16, DEPTH = 4, START_CYC = 2, TIMEOUT = 255;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0, rst = 1'b1;
    logic          in_valid = 1'b0, in_ready;
    logic [W-1:0]  in_a = '0, in_b = '0;
    logic          res_valid, res_ready = 1'b0, res_err;
    logic [W-1:0]  res_data;
    logic          dp_start, dp_done = 1'b0;
    logic [W-1:0]  dp_a, dp_b, dp_result = '0;
    logic          busy;
    logic [CW-1:0] fifo_count;

    job_issuer #(.W(W), .DEPTH(DEPTH), .START_CYC(START_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b), .dp_done(dp_done), .dp_result(dp_result),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [W:0] exp_q[$];
    logic [W:0] got_q[$];

    // Datapath responder: pulses dp_done with a*b a set latency after dp_start falls.
    bit   resp_en = 1'b0;
    int   lat_fixed = 10;
    int   rcnt = 0;
    logic r_prev_start = 1'b0;
    always @(negedge clk) begin
        dp_done = 1'b0;
        if (rst) rcnt = 0;
        else if (r_prev_start && !dp_start && resp_en)
            rcnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 50));
        else if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin
                dp_done   = 1'b1;
                dp_result = dp_a * dp_b;
            end
        end
        r_prev_start = dp_start;
    end

    // Monitor: start pulse length, wait length, stability rules, handshake capture.
    int   start_run = 0, last_run = 0, wait_cnt = 0, last_wait = 0;
    int   viol = 0, start_cyc = 0, max_cnt = 0;
    logic m_prev_busy = 1'b0, m_prev_rv = 1'b0, m_prev_hs = 1'b0, m_prev_re = 1'b0;
    logic [W-1:0] held_a = '0, held_b = '0, m_prev_rd = '0;
    always @(negedge clk) begin
        if (rst) begin
            start_run = 0;
            wait_cnt  = 0;
        end else begin
            if (dp_start) begin
                start_run++;
                start_cyc++;
                wait_cnt = 0;
            end else if (start_run > 0) begin
                last_run  = start_run;
                start_run = 0;
            end
            if (busy && !dp_start && !res_valid) wait_cnt++;
            if (res_valid && !m_prev_rv) last_wait = wait_cnt;
            if (busy && !m_prev_busy) begin
                held_a = dp_a;
                held_b = dp_b;
            end else if (busy && (dp_a !== held_a || dp_b !== held_b)) viol++;
            if (res_valid && m_prev_rv && !m_prev_hs &&
                (res_data !== m_prev_rd || res_err !== m_prev_re)) viol++;
            if (res_valid && dp_start) viol++;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (res_valid && res_ready) got_q.push_back({res_err, res_data});
        end
        m_prev_busy = busy;
        m_prev_rv   = res_valid;
        m_prev_hs   = res_valid && res_ready && !rst;
        m_prev_rd   = res_data;
        m_prev_re   = res_err;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input bit err, input bit track);
        int n = 0;
        logic [W-1:0] prod;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (!in_ready && n < 3000) begin
            step();
            n++;
        end
        chk("push_accept", in_ready, 1);
        step();
        in_valid = 1'b0;
        prod = a * b;
        if (track) exp_q.push_back(err ? {1'b1, {W{1'b0}}} : {1'b0, prod});
    endtask

    task automatic wait_rv(input string tag);
        int n = 0;
        while (!res_valid && n < 2000) begin
            step();
            n++;
        end
        chk(tag, res_valid, 1);
        step();
    endtask

    task automatic wait_results(input string tag, input int k);
        int n = 0;
        while (got_q.size() < k && n < 4000) begin
            step();
            n++;
        end
        chk(tag, got_q.size(), k);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, s0, n;
        logic [W-1:0] ra, rb;

        // reset state
        repeat (3) step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_dp_start", dp_start, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_dp_ab", {dp_a, dp_b}, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", in_ready, 1);

        // single job, datapath answers 10 cycles after dp_start falls
        resp_en = 1'b1;
        lat_fixed = 10;
        push(16'h00F0, 16'h0003, 1'b0, 1'b1);
        wait_rv("single_rv");
        chk("single_data", res_data, 16'h02D0);
        chk("single_err", res_err, 0);
        chk("single_start_len", last_run, START_CYC);
        chk("single_wait_len", last_wait, 11);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        step();
        chk("single_idle", busy, 0);

        // timeout, then fill while the result is held
        resp_en = 1'b0;
        push(16'd1, 16'd2, 1'b1, 1'b1);
        wait_rv("to_rv");
        chk("to_wait_len", last_wait, TIMEOUT);
        chk("to_err", res_err, 1);
        chk("to_data", res_data, 0);
        for (int i = 0; i < 4; i++) push(W'(i + 3), W'(i + 5), 1'b1, 1'b1);
        chk("fill_count", fifo_count, DEPTH);
        chk("fill_ready", in_ready, 0);
        fork
            push(16'd9, 16'd9, 1'b1, 1'b1);
            begin
                repeat (10) step();
                chk("fill_blocked", fifo_count, DEPTH);
                res_ready = 1'b1;
            end
        join
        wait_results("fill_results", 7);
        chk("fill_max_count", max_cnt, DEPTH);
        res_ready = 1'b0;

        // backpressure with two pairs queued
        resp_en = 1'b1;
        lat_fixed = 0;
        k = got_q.size();
        push(W'($urandom), W'($urandom), 1'b0, 1'b1);
        push(W'($urandom), W'($urandom), 1'b0, 1'b1);
        wait_rv("bp_rv");
        s0 = start_cyc;
        repeat (20) step();
        chk("bp_no_start", start_cyc, s0);
        chk("bp_queued", fifo_count, 1);
        chk("bp_held", res_valid, 1);
        res_ready = 1'b1;
        wait_results("bp_results", k + 2);

        // ordering with random latency and operands
        k = got_q.size();
        for (int i = 0; i < 4; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            push(ra, rb, 1'b0, 1'b1);
        end
        wait_results("ord_results", k + 4);

        // reset in the middle of a job with three pairs queued
        resp_en = 1'b0;
        k = got_q.size();
        for (int i = 0; i < 4; i++) push(W'(i + 100), W'(7), 1'b1, 1'b0);
        n = 0;
        while (!(busy && !dp_start && !res_valid) && n < 100) begin
            step();
            n++;
        end
        chk("mid_in_wait", busy && !dp_start && !res_valid, 1);
        chk("mid_queued", fifo_count, 3);
        rst = 1'b1;
        step();
        chk("mid_rst_dp_start", dp_start, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        repeat (300) step();
        chk("mid_no_result", got_q.size(), k);
        chk("mid_still_idle", busy, 0);

        // scoreboard: every delivered result in push order
        chk("n_results", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("result%0d", i), got_q[i], exp_q[i]);
        chk("protocol_viol", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
